// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and slot helpers for the codec master
// and the I2S read/write blocks.
package i2s_pkg;

    localparam int          DATA_W_DEF = 32'd16;
    localparam int unsigned MSB_SLOT   = 32'd1;
    localparam logic        LEFT_LEVEL = 1'b0;  // lrclk level during the left half

    // True when a slot index carries one bit of a data_w-bit word.
    function automatic logic is_data_slot(input int unsigned slot, input int unsigned data_w);
        is_data_slot = (slot >= MSB_SLOT) && (slot < (MSB_SLOT + data_w));
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider and slot counter: derives bclk, lrclk, the bclk edge
// strobes and the frame-start strobe from the master clock.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int MCLK_PER_BCLK = 32'd4,
    parameter int BCLK_PER_HALF = 32'd192
) (
    input  logic                             clk_p,
    input  logic                             rst,
    output logic                             bclk,
    output logic                             lrclk,
    output logic                             fall_stb,
    output logic                             rise_stb,
    output logic [$clog2(BCLK_PER_HALF)-1:0] slot,
    output logic                             frame_start
);

    localparam int DIV_W  = $clog2(MCLK_PER_BCLK);
    localparam int SLOT_W = $clog2(BCLK_PER_HALF);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MCLK_PER_BCLK - 32'd1);
    localparam logic [DIV_W-1:0]  DIV_RISE  = DIV_W'((MCLK_PER_BCLK / 32'd2) - 32'd1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BCLK_PER_HALF - 32'd1);

    logic [DIV_W-1:0]  div_r;
    logic [SLOT_W-1:0] slot_r;
    logic              bclk_r;
    logic              lrclk_r;
    logic              fall_s;
    logic              rise_s;
    logic              wrap_s;

    // Strobes mark the cycle whose closing edge moves bclk
    always_comb begin
        fall_s = (div_r == DIV_LAST);
        rise_s = (div_r == DIV_RISE);
        wrap_s = fall_s && (slot_r == SLOT_LAST);
    end

    // Divider, registered bit clock, slot counter and frame clock
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            div_r   <= {DIV_W{1'b0}};
            slot_r  <= {SLOT_W{1'b0}};
            bclk_r  <= 1'b0;
            lrclk_r <= LEFT_LEVEL;
        end else if (fall_s) begin
            div_r   <= {DIV_W{1'b0}};
            bclk_r  <= 1'b0;
            slot_r  <= wrap_s ? {SLOT_W{1'b0}} : (slot_r + SLOT_W'(1'b1));
            lrclk_r <= wrap_s ? ~lrclk_r : lrclk_r;
        end else begin
            div_r  <= div_r + DIV_W'(1'b1);
            bclk_r <= rise_s ? 1'b1 : bclk_r;
        end
    end

    assign bclk        = bclk_r;
    assign lrclk       = lrclk_r;
    assign fall_stb    = fall_s;
    assign rise_stb    = rise_s;
    assign slot        = slot_r;
    assign frame_start = wrap_s && (lrclk_r != LEFT_LEVEL);

endmodule

// File: rtl/i2s_codec_master.sv
// Codec-side I2S bus master: generates bclk/lrclk, serializes one mono sample
// per frame onto adcdat and deserializes the left-half word from dacdat.
module i2s_codec_master
    import i2s_pkg::*;
#(
    parameter int MCLK_PER_BCLK = 32'd4,
    parameter int BCLK_PER_HALF = 32'd192,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic              clk_p,
    input  logic              rst,
    output logic              bclk,
    output logic              lrclk,
    output logic              adcdat,
    input  logic              dacdat,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun
);

    localparam int SLOT_W = $clog2(BCLK_PER_HALF);
    localparam logic [SLOT_W-1:0] LSB_SLOT = SLOT_W'(MSB_SLOT + 32'(DATA_W) - 32'd1);

    logic              bclk_s;
    logic              lrclk_s;
    logic              fall_s;
    logic              rise_s;
    logic [SLOT_W-1:0] slot_s;
    logic              frame_s;

    logic              left_s;
    logic              tx_bit_s;
    logic              rx_bit_s;
    logic              rx_last_s;
    logic              accept_s;

    logic [DATA_W-1:0] tx_buf_r;
    logic              tx_ready_r;
    logic [DATA_W-1:0] tx_sh_r;
    logic [DATA_W-1:0] last_r;
    logic              adcdat_r;
    logic              underrun_r;
    logic [DATA_W-1:0] rx_sh_r;
    logic              rx_done_r;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r;

    i2s_clk_gen #(
        .MCLK_PER_BCLK (MCLK_PER_BCLK),
        .BCLK_PER_HALF (BCLK_PER_HALF)
    ) u_clk_gen (
        .clk_p       (clk_p),
        .rst         (rst),
        .bclk        (bclk_s),
        .lrclk       (lrclk_s),
        .fall_stb    (fall_s),
        .rise_stb    (rise_s),
        .slot        (slot_s),
        .frame_start (frame_s)
    );

    // Slot qualifiers: TX looks at the slot being entered, RX at the current one
    always_comb begin
        left_s    = (lrclk_s == LEFT_LEVEL);
        tx_bit_s  = fall_s && left_s && is_data_slot(32'(slot_s) + 32'd1, 32'(DATA_W));
        rx_bit_s  = rise_s && left_s && is_data_slot(32'(slot_s), 32'(DATA_W));
        rx_last_s = rx_bit_s && (slot_s == LSB_SLOT);
        accept_s  = tx_valid && tx_ready_r;
    end

    // TX holding buffer, frame-start load/underrun and MSB-first serializer
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            tx_buf_r   <= {DATA_W{1'b0}};
            tx_ready_r <= 1'b1;
            tx_sh_r    <= {DATA_W{1'b0}};
            last_r     <= {DATA_W{1'b0}};
            adcdat_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= frame_s && tx_ready_r;
            // A write landing on frame start with an empty buffer waits for the next frame
            if (accept_s) begin
                tx_buf_r   <= tx_data;
                tx_ready_r <= 1'b0;
            end else if (frame_s) begin
                tx_ready_r <= 1'b1;
            end
            if (frame_s) begin
                adcdat_r <= 1'b0;
                if (!tx_ready_r) begin
                    tx_sh_r <= tx_buf_r;
                    last_r  <= tx_buf_r;
                end else begin
                    tx_sh_r <= last_r;
                end
            end else if (tx_bit_s) begin
                adcdat_r <= tx_sh_r[DATA_W-1];
                tx_sh_r  <= {tx_sh_r[DATA_W-2:0], 1'b0};
            end else if (fall_s) begin
                adcdat_r <= 1'b0;
            end
        end
    end

    // RX deserializer on rising bclk, word published one cycle after the LSB
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            rx_sh_r    <= {DATA_W{1'b0}};
            rx_done_r  <= 1'b0;
            rx_data_r  <= {DATA_W{1'b0}};
            rx_valid_r <= 1'b0;
        end else begin
            if (rx_bit_s) begin
                rx_sh_r <= {rx_sh_r[DATA_W-2:0], dacdat};
            end
            rx_done_r  <= rx_last_s;
            rx_valid_r <= rx_done_r;
            if (rx_done_r) begin
                rx_data_r <= rx_sh_r;
            end
        end
    end

    assign bclk     = bclk_s;
    assign lrclk    = lrclk_s;
    assign adcdat   = adcdat_r;
    assign tx_ready = tx_ready_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign underrun = underrun_r;

endmodule

// File: tb/tb_i2s_codec_master.sv
// Self-checking bench for i2s_codec_master at default parameters, with a
// frame-level scoreboard for transmitted and received samples.
module tb_i2s_codec_master;

    localparam int M     = 4;
    localparam int BPH   = 192;
    localparam int DW    = 16;
    localparam int HALF  = M * BPH;
    localparam int FRAME = 2 * HALF;

    logic        clk_p      = 1'b0;
    logic        rst        = 1'b0;
    logic        bclk;
    logic        lrclk;
    logic        adcdat;
    logic        dacdat;
    logic        dacdat_drv = 1'b0;
    logic        loop_en    = 1'b0;
    logic [15:0] tx_data    = 16'h0000;
    logic        tx_valid   = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        underrun;

    int          cyc;
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    logic [15:0] last_word = 16'h0000;

    assign dacdat = loop_en ? adcdat : dacdat_drv;

    i2s_codec_master dut (
        .clk_p    (clk_p),
        .rst      (rst),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .adcdat   (adcdat),
        .dacdat   (dacdat),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .underrun (underrun)
    );

    always #5 clk_p = ~clk_p;

    // Cycle index since reset release: cycle 0 is the first div=0, slot=0 cycle
    always @(posedge clk_p or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Expected serial bit of word w during cycle k in I2S left-justified-by-one timing
    function automatic logic exp_adc(input logic [15:0] w, input int k);
        int r;
        int s;
        r = k % FRAME;
        s = r / M;
        if (r < HALF && s >= 1 && s <= DW) return w[DW - s];
        return 1'b0;
    endfunction

    task automatic step();
        @(negedge clk_p);
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) step();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (4) step();
        total_cnt++;
        if ({bclk, lrclk, adcdat, tx_ready, rx_valid, underrun, rx_data} !== {6'b000100, 16'h0000})
            $display("FAIL reset_values: got bclk=%b lrclk=%b adc=%b rdy=%b rxv=%b ur=%b rx=%h want 0 0 0 1 0 0 0000",
                     bclk, lrclk, adcdat, tx_ready, rx_valid, underrun, rx_data);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        int   bad_bclk = 0, bad_lr = 0, lr_tog = 0, adc_ones = 0, ur_cnt = 0, ur_at = -1;
        logic lr_prev;
        lr_prev = lrclk;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (bclk !== ((cyc % M) >= (M / 2))) bad_bclk++;
            if (lrclk !== (((cyc / HALF) % 2) == 1)) bad_lr++;
            if (i > 0 && lrclk !== lr_prev) lr_tog++;
            lr_prev = lrclk;
            if (adcdat !== 1'b0) adc_ones++;
            if (underrun === 1'b1) begin ur_cnt++; ur_at = cyc; end
            step();
        end
        total_cnt++;
        if (bad_bclk != 0) $display("FAIL bclk_period: got %0d bad cycles want 0", bad_bclk); else pass_cnt++;
        total_cnt++;
        if (bad_lr != 0) $display("FAIL lrclk_phase: got %0d bad cycles want 0", bad_lr); else pass_cnt++;
        total_cnt++;
        if (lr_tog != 3) $display("FAIL lrclk_toggles: got %0d want 3", lr_tog); else pass_cnt++;
        total_cnt++;
        if (adc_ones != 0) $display("FAIL idle_adcdat: got %0d high cycles want 0", adc_ones); else pass_cnt++;
        total_cnt++;
        if (ur_cnt != 1 || ur_at != FRAME)
            $display("FAIL idle_underrun: got %0d pulses last at %0d want 1 at %0d", ur_cnt, ur_at, FRAME);
        else pass_cnt++;
    endtask

    task automatic test_tx_pattern();
        logic [15:0] cur;
        int bad_adc = 0, bad_rdy = 0;
        goto_cycle(3 * FRAME - 1000);
        total_cnt++;
        if (tx_ready !== 1'b1) $display("FAIL tx_ready_idle: got %b want 1", tx_ready); else pass_cnt++;
        tx_data  = 16'hA5C3;
        tx_valid = 1'b1;
        tx_q.push_back(16'hA5C3);
        step();
        tx_valid = 1'b0;
        total_cnt++;
        if (tx_ready !== 1'b0) $display("FAIL tx_ready_after_accept: got %b want 0", tx_ready); else pass_cnt++;
        goto_cycle(3 * FRAME - 1);
        total_cnt++;
        if (tx_ready !== 1'b0) $display("FAIL tx_ready_before_frame: got %b want 0", tx_ready); else pass_cnt++;
        step();
        total_cnt++;
        if (underrun !== 1'b0) $display("FAIL tx_no_underrun: got %b want 0", underrun); else pass_cnt++;
        cur = tx_q.pop_front();
        last_word = cur;
        for (int i = 0; i < FRAME; i++) begin
            if (adcdat !== exp_adc(cur, cyc)) bad_adc++;
            if (tx_ready !== 1'b1) bad_rdy++;
            step();
        end
        total_cnt++;
        if (bad_adc != 0) $display("FAIL tx_pattern: got %0d bad adcdat cycles want 0", bad_adc); else pass_cnt++;
        total_cnt++;
        if (bad_rdy != 0) $display("FAIL tx_ready_frame: got %0d low cycles want 0", bad_rdy); else pass_cnt++;
    endtask

    task automatic test_rx();
        logic [15:0] exp;
        int rv_cnt = 0, rv_at = -1;
        goto_cycle(4 * FRAME);
        rx_q.push_back(16'h8001);
        for (int i = 0; i < HALF; i++) begin
            dacdat_drv = exp_adc(16'h8001, cyc);
            if (rx_valid === 1'b1) begin
                rv_cnt++;
                rv_at = cyc - 4 * FRAME;
                total_cnt++;
                if (rx_q.size() == 0) $display("FAIL rx_word: got %h with nothing expected", rx_data);
                else begin
                    exp = rx_q.pop_front();
                    if (rx_data !== exp) $display("FAIL rx_word: got %h want %h", rx_data, exp);
                    else pass_cnt++;
                end
            end
            step();
        end
        dacdat_drv = 1'b0;
        total_cnt++;
        if (rv_cnt != 1 || rv_at != (DW * M + M / 2 + 1))
            $display("FAIL rx_valid_timing: got %0d pulses at %0d want 1 at %0d", rv_cnt, rv_at, DW * M + M / 2 + 1);
        else pass_cnt++;
    endtask

    task automatic test_loopback();
        logic [15:0] next_w[2];
        logic [15:0] cur, exp;
        int bad_adc = 0, ur_cnt = 0, rv_cnt = 0, wi = 0;
        next_w[0] = 16'h8000;
        next_w[1] = 16'h0000;
        cur       = last_word;
        loop_en   = 1'b1;
        tx_data   = 16'h7FFF;
        tx_valid  = 1'b1;
        tx_q.push_back(16'h7FFF);
        rx_q.push_back(16'h7FFF);
        step();
        tx_valid = 1'b0;
        goto_cycle(5 * FRAME);
        for (int i = 0; i < 3 * FRAME; i++) begin
            if ((cyc % FRAME) == 0) begin
                if (tx_q.size() > 0) cur = tx_q.pop_front();
                else                 cur = last_word;
                last_word = cur;
            end
            if ((cyc % FRAME) == 100 && wi < 2) begin
                tx_data  = next_w[wi];
                tx_valid = 1'b1;
                tx_q.push_back(next_w[wi]);
                rx_q.push_back(next_w[wi]);
                wi++;
            end else begin
                tx_valid = 1'b0;
            end
            if (adcdat !== exp_adc(cur, cyc)) bad_adc++;
            if (underrun === 1'b1) ur_cnt++;
            if (rx_valid === 1'b1) begin
                rv_cnt++;
                total_cnt++;
                if (rx_q.size() == 0) $display("FAIL loopback_rx: got %h with nothing expected", rx_data);
                else begin
                    exp = rx_q.pop_front();
                    if (rx_data !== exp) $display("FAIL loopback_rx: got %h want %h", rx_data, exp);
                    else pass_cnt++;
                end
            end
            step();
        end
        tx_valid = 1'b0;
        total_cnt++;
        if (bad_adc != 0) $display("FAIL loopback_adcdat: got %0d bad cycles want 0", bad_adc); else pass_cnt++;
        total_cnt++;
        if (ur_cnt != 0) $display("FAIL loopback_underrun: got %0d pulses want 0", ur_cnt); else pass_cnt++;
        total_cnt++;
        if (rv_cnt != 3) $display("FAIL loopback_rx_count: got %0d want 3", rv_cnt); else pass_cnt++;
    endtask

    task automatic test_skip_write();
        logic [15:0] cur, exp;
        logic exp_u;
        int bad_adc = 0, bad_ur = 0, bad_rdy = 0, ur_cnt = 0, rv_cnt = 0;
        cur = last_word;
        goto_cycle(8 * FRAME);
        for (int i = 0; i < 3 * FRAME; i++) begin
            exp_u = 1'b0;
            if ((cyc % FRAME) == 0) begin
                if (tx_q.size() > 0) cur = tx_q.pop_front();
                else begin cur = last_word; exp_u = 1'b1; end
                last_word = cur;
                rx_q.push_back(cur);
            end
            if (cyc == 8 * FRAME + 100) begin
                tx_data  = 16'h3C5A;
                tx_valid = 1'b1;
                tx_q.push_back(16'h3C5A);
            end else begin
                tx_valid = 1'b0;
            end
            if (adcdat !== exp_adc(cur, cyc)) bad_adc++;
            if (underrun !== exp_u) bad_ur++;
            if (underrun === 1'b1) ur_cnt++;
            if (cyc >= 9 * FRAME && tx_ready !== 1'b1) bad_rdy++;
            if (rx_valid === 1'b1) begin
                rv_cnt++;
                total_cnt++;
                if (rx_q.size() == 0) $display("FAIL skip_rx: got %h with nothing expected", rx_data);
                else begin
                    exp = rx_q.pop_front();
                    if (rx_data !== exp) $display("FAIL skip_rx: got %h want %h", rx_data, exp);
                    else pass_cnt++;
                end
            end
            step();
        end
        total_cnt++;
        if (bad_adc != 0) $display("FAIL skip_resend: got %0d bad adcdat cycles want 0", bad_adc); else pass_cnt++;
        total_cnt++;
        if (bad_ur != 0 || ur_cnt != 2)
            $display("FAIL skip_underrun: got %0d misplaced, %0d pulses want 0 misplaced, 2 pulses", bad_ur, ur_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bad_rdy != 0) $display("FAIL skip_tx_ready: got %0d low cycles want 0", bad_rdy); else pass_cnt++;
        total_cnt++;
        if (rv_cnt != 3) $display("FAIL skip_rx_count: got %0d want 3", rv_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int adc_ones = 0, ur_cnt = 0, rv_cnt = 0, rv_at = -1, bad_hold = 0;
        goto_cycle(11 * FRAME + 100);
        tx_data  = 16'hFFFF;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        goto_cycle(12 * FRAME + 8 * M);
        total_cnt++;
        if (adcdat !== 1'b1) $display("FAIL mid_transfer_bit: got %b want 1", adcdat); else pass_cnt++;
        step();
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bclk, lrclk, adcdat, tx_ready, rx_valid, underrun, rx_data} !== {6'b000100, 16'h0000})
            $display("FAIL reset_abort: got bclk=%b lrclk=%b adc=%b rdy=%b rxv=%b ur=%b rx=%h want 0 0 0 1 0 0 0000",
                     bclk, lrclk, adcdat, tx_ready, rx_valid, underrun, rx_data);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rx_valid !== 1'b0 || underrun !== 1'b0 || bclk !== 1'b0) bad_hold++;
        end
        rst = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (adcdat !== 1'b0) adc_ones++;
            if (underrun === 1'b1) ur_cnt++;
            if (rx_valid === 1'b1) begin
                rv_cnt++;
                rv_at = cyc;
                total_cnt++;
                if (rx_data !== 16'h0000) $display("FAIL post_reset_rx: got %h want 0000", rx_data);
                else pass_cnt++;
            end
            step();
        end
        total_cnt++;
        if (bad_hold != 0) $display("FAIL reset_hold: got %0d active cycles want 0", bad_hold); else pass_cnt++;
        total_cnt++;
        if (adc_ones != 0) $display("FAIL post_reset_adcdat: got %0d high cycles want 0", adc_ones); else pass_cnt++;
        total_cnt++;
        if (ur_cnt != 0) $display("FAIL post_reset_underrun: got %0d pulses want 0", ur_cnt); else pass_cnt++;
        total_cnt++;
        if (rv_cnt != 1 || rv_at != 67) $display("FAIL post_reset_rx_valid: got %0d pulses at %0d want 1 at 67", rv_cnt, rv_at);
        else pass_cnt++;
        total_cnt++;
        if (underrun !== 1'b1) $display("FAIL post_reset_second_frame: got underrun %b want 1", underrun); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_tx_pattern();
        test_rx();
        test_loopback();
        test_skip_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
